// File: rtl/stack_pkg.sv
// Shared constants for the stack sequencer: micro-op codes, response error codes
// and FSM state encoding.
package stack_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_BINOP = 3'd3;
    localparam logic [2:0] OP_UNOP  = 3'd4;
    localparam logic [2:0] OP_DUP   = 3'd5;
    localparam logic [2:0] OP_SWAP  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;
    localparam logic [1:0] ERR_ILL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DUP_PUSH = 2'd1,
        SWAP_P1  = 2'd2,
        SWAP_P2  = 2'd3
    } state_t;

endpackage

// File: rtl/stack_op_check.sv
// Combinational legality check for a stack micro-op against the current depth.
// Reports the error code (illegal > underflow > overflow) and the net depth change.
module stack_op_check
    import stack_pkg::*;
#(
    parameter int DEPTH_MAX = 1024,
    parameter int DW        = $clog2(DEPTH_MAX + 1)
) (
    input  logic [2:0]    op_code,
    input  logic [DW-1:0] depth,
    output logic [1:0]    err,
    output logic          depth_inc,
    output logic          depth_dec
);

    localparam logic [DW-1:0] MAX_D = DW'(DEPTH_MAX);

    logic lt1, lt2, at_max;

    assign lt1    = (depth == '0);
    assign lt2    = lt1 || (depth == DW'(1));
    assign at_max = (depth >= MAX_D);

    always_comb begin
        err       = ERR_OK;
        depth_inc = 1'b0;
        depth_dec = 1'b0;
        case (op_code)
            OP_NOP: ;
            OP_PUSH:  if (at_max) err = ERR_OVER;  else depth_inc = 1'b1;
            OP_POP:   if (lt1)    err = ERR_UNDER; else depth_dec = 1'b1;
            OP_BINOP: if (lt2)    err = ERR_UNDER; else depth_dec = 1'b1;
            OP_UNOP:  if (lt1)    err = ERR_UNDER;
            OP_DUP: begin
                if (lt1)         err = ERR_UNDER;
                else if (at_max) err = ERR_OVER;
                else             depth_inc = 1'b1;
            end
            OP_SWAP:  if (lt2)    err = ERR_UNDER;
            default:  err = ERR_ILL;
        endcase
    end

endmodule

// File: rtl/stack_seq_ctrl.sv
// Stack micro-op sequencer: accepts one op per handshake, expands DUP/SWAP into
// multi-cycle register-file strobe sequences, tracks depth and routes ALU operands.
module stack_seq_ctrl
    import stack_pkg::*;
#(
    parameter int DBITS     = 32,
    parameter int DEPTH_MAX = 1024,
    parameter int FN_BITS   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             op_valid,
    output logic                             op_ready,
    input  logic [2:0]                       op_code,
    input  logic [FN_BITS-1:0]               op_fn,
    input  logic [DBITS-1:0]                 op_data,
    output logic                             rf_en1,
    output logic                             rf_en2,
    output logic                             rf_we,
    output logic [DBITS-1:0]                 rf_din,
    input  logic [DBITS-1:0]                 rf_dout1,
    input  logic [DBITS-1:0]                 rf_dout2,
    output logic [FN_BITS-1:0]               alu_fn,
    output logic [DBITS-1:0]                 alu_a,
    output logic [DBITS-1:0]                 alu_b,
    input  logic [DBITS-1:0]                 alu_y,
    output logic                             rsp_valid,
    output logic [DBITS-1:0]                 rsp_data,
    output logic [1:0]                       rsp_err,
    output logic [$clog2(DEPTH_MAX+1)-1:0]   depth
);

    localparam int DW = $clog2(DEPTH_MAX + 1);

    state_t           state_reg, state_next;
    logic [DBITS-1:0] cap_a_reg, cap_a_next;
    logic [DBITS-1:0] cap_b_reg, cap_b_next;
    logic [DW-1:0]    depth_reg, depth_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic [DBITS-1:0] rsp_data_reg, rsp_data_next;
    logic [1:0]       rsp_err_reg, rsp_err_next;

    logic       accept;
    logic [1:0] chk_err;
    logic       chk_inc, chk_dec;

    stack_op_check #(
        .DEPTH_MAX (DEPTH_MAX),
        .DW        (DW)
    ) u_check (
        .op_code   (op_code),
        .depth     (depth_reg),
        .err       (chk_err),
        .depth_inc (chk_inc),
        .depth_dec (chk_dec)
    );

    assign op_ready  = (state_reg == IDLE);
    assign accept    = op_valid & op_ready;
    assign alu_a     = rf_dout1;
    assign alu_b     = rf_dout2;
    assign depth     = depth_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;

    always_comb begin
        state_next     = state_reg;
        cap_a_next     = cap_a_reg;
        cap_b_next     = cap_b_reg;
        depth_next     = depth_reg;
        rsp_valid_next = 1'b0;
        rsp_data_next  = '0;
        rsp_err_next   = ERR_OK;
        rf_en1         = 1'b0;
        rf_en2         = 1'b0;
        rf_we          = 1'b0;
        rf_din         = '0;
        alu_fn         = '0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    alu_fn         = op_fn;
                    rsp_valid_next = 1'b1;
                    if (chk_err != ERR_OK) begin
                        rsp_err_next = chk_err;
                    end else begin
                        // DUP's increment lands when its second push completes
                        if (chk_inc && op_code != OP_DUP) depth_next = depth_reg + DW'(1);
                        if (chk_dec)                      depth_next = depth_reg - DW'(1);
                        case (op_code)
                            OP_PUSH: begin
                                rf_we  = 1'b1;
                                rf_din = op_data;
                            end
                            OP_POP: begin
                                rf_en1        = 1'b1;
                                rsp_data_next = rf_dout1;
                            end
                            OP_BINOP: begin
                                rf_en1        = 1'b1;
                                rf_en2        = 1'b1;
                                rf_we         = 1'b1;
                                rf_din        = alu_y;
                                rsp_data_next = alu_y;
                            end
                            OP_UNOP: begin
                                rf_en1        = 1'b1;
                                rf_we         = 1'b1;
                                rf_din        = alu_y;
                                rsp_data_next = alu_y;
                            end
                            OP_DUP: begin
                                rf_en1         = 1'b1;
                                rf_we          = 1'b1;
                                rf_din         = rf_dout1;
                                cap_a_next     = rf_dout1;
                                rsp_valid_next = 1'b0;
                                state_next     = DUP_PUSH;
                            end
                            OP_SWAP: begin
                                rf_en1         = 1'b1;
                                rf_en2         = 1'b1;
                                cap_a_next     = rf_dout1;
                                cap_b_next     = rf_dout2;
                                rsp_valid_next = 1'b0;
                                state_next     = SWAP_P1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            DUP_PUSH: begin
                rf_we          = 1'b1;
                rf_din         = cap_a_reg;
                depth_next     = depth_reg + DW'(1);
                rsp_valid_next = 1'b1;
                state_next     = IDLE;
            end
            // Old top goes back first so the old next ends up on top
            SWAP_P1: begin
                rf_we      = 1'b1;
                rf_din     = cap_a_reg;
                state_next = SWAP_P2;
            end
            SWAP_P2: begin
                rf_we          = 1'b1;
                rf_din         = cap_b_reg;
                rsp_valid_next = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cap_a_reg     <= '0;
            cap_b_reg     <= '0;
            depth_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= ERR_OK;
        end else begin
            state_reg     <= state_next;
            cap_a_reg     <= cap_a_next;
            cap_b_reg     <= cap_b_next;
            depth_reg     <= depth_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Directed bench for stack_seq_ctrl with a behavioural register-file stack and ALU.
module tb_stack_seq_ctrl;

    localparam int DB = 32;
    localparam int DM = 4;
    localparam int FB = 4;
    localparam int DW = $clog2(DM + 1);

    logic          clk, rst_n, op_valid, op_ready;
    logic [2:0]    op_code;
    logic [FB-1:0] op_fn, alu_fn;
    logic [DB-1:0] op_data, rf_din, rf_dout1, rf_dout2, alu_a, alu_b, alu_y, rsp_data;
    logic          rf_en1, rf_en2, rf_we, rsp_valid;
    logic [1:0]    rsp_err;
    logic [DW-1:0] depth;
    logic [2:0]    strb;

    int total = 0;
    int bad   = 0;

    stack_seq_ctrl #(.DBITS(DB), .DEPTH_MAX(DM), .FN_BITS(FB)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_fn(op_fn), .op_data(op_data),
        .rf_en1(rf_en1), .rf_en2(rf_en2), .rf_we(rf_we), .rf_din(rf_din),
        .rf_dout1(rf_dout1), .rf_dout2(rf_dout2),
        .alu_fn(alu_fn), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .depth(depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign strb = {rf_en1, rf_en2, rf_we};

    // ALU: 1 add, 2 sub, 3 invert
    always_comb begin
        case (alu_fn)
            4'd1:    alu_y = alu_a + alu_b;
            4'd2:    alu_y = alu_a - alu_b;
            4'd3:    alu_y = ~alu_a;
            default: alu_y = '0;
        endcase
    end

    // Register-file stack: en1/en2 each pop one, we pushes one
    logic [DB-1:0] mem [0:15];
    int sp, sp_next;
    assign sp_next  = sp - int'(rf_en1) - int'(rf_en2) + int'(rf_we);
    assign rf_dout1 = (sp >= 1) ? mem[sp-1] : '0;
    assign rf_dout2 = (sp >= 2) ? mem[sp-2] : '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            sp <= 0;
        end else begin
            if (rf_we && sp_next >= 1 && sp_next <= 16) mem[sp_next-1] <= rf_din;
            sp <= sp_next;
        end
    end

    task automatic step(input logic v, input logic [2:0] c, input logic [3:0] f, input logic [31:0] d);
        @(negedge clk);
        op_valid = v; op_code = c; op_fn = f; op_data = d;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(0, 3'd0, 4'd0, 0);
        step(0, 3'd0, 4'd0, 0);
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", op_ready); end
        total++; if (depth !== 0) begin bad++; $display("FAIL rst_depth got=%0d exp=0", depth); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_data !== 0) begin bad++; $display("FAIL rst_rsp_data got=%0h exp=0", rsp_data); end
        total++; if (rsp_err !== 2'b00) begin bad++; $display("FAIL rst_rsp_err got=%b exp=00", rsp_err); end
        total++; if (strb !== 3'b000) begin bad++; $display("FAIL rst_strb got=%b exp=000", strb); end
        rst_n = 1'b1;
        $display("test_reset done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_push_binop_pop();
        step(1, 3'd1, 4'd0, 5);
        total++; if (strb !== 3'b001) begin bad++; $display("FAIL t1_push5_strb got=%b exp=001", strb); end
        total++; if (rf_din !== 5) begin bad++; $display("FAIL t1_push5_din got=%0h exp=5", rf_din); end
        step(1, 3'd1, 4'd0, 7);
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 2'b00) begin bad++; $display("FAIL t1_push5_rsp got=%b/%b exp=1/00", rsp_valid, rsp_err); end
        total++; if (depth !== 1) begin bad++; $display("FAIL t1_depth1 got=%0d exp=1", depth); end
        total++; if (strb !== 3'b001 || rf_din !== 7) begin bad++; $display("FAIL t1_push7 got=%b/%0h exp=001/7", strb, rf_din); end
        step(1, 3'd3, 4'd1, 0);
        total++; if (depth !== 2) begin bad++; $display("FAIL t1_depth2 got=%0d exp=2", depth); end
        total++; if (strb !== 3'b111) begin bad++; $display("FAIL t1_binop_strb got=%b exp=111", strb); end
        total++; if (rf_din !== 12) begin bad++; $display("FAIL t1_binop_din got=%0h exp=c", rf_din); end
        total++; if (alu_fn !== 4'd1) begin bad++; $display("FAIL t1_alu_fn got=%0h exp=1", alu_fn); end
        step(1, 3'd2, 4'd0, 0);
        total++; if (rsp_data !== 12) begin bad++; $display("FAIL t1_binop_rsp got=%0h exp=c", rsp_data); end
        total++; if (depth !== 1) begin bad++; $display("FAIL t1_binop_depth got=%0d exp=1", depth); end
        total++; if (strb !== 3'b100) begin bad++; $display("FAIL t1_pop_strb got=%b exp=100", strb); end
        step(0, 3'd0, 4'd0, 0);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 12) begin bad++; $display("FAIL t1_pop_rsp got=%b/%0h exp=1/c", rsp_valid, rsp_data); end
        total++; if (depth !== 0) begin bad++; $display("FAIL t1_pop_depth got=%0d exp=0", depth); end
        total++; if (alu_fn !== 4'd0 || strb !== 3'b000) begin bad++; $display("FAIL t1_idle_out got=%0h/%b exp=0/000", alu_fn, strb); end
        step(0, 3'd0, 4'd0, 0);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL t1_rsp_pulse got=%b exp=0", rsp_valid); end
        $display("test_push_binop_pop done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_swap();
        step(1, 3'd1, 4'd0, 1);
        step(1, 3'd1, 4'd0, 2);
        step(1, 3'd6, 4'd0, 0);
        total++; if (strb !== 3'b110 || op_ready !== 1'b1) begin bad++; $display("FAIL t2_swap_acc got=%b/%b exp=110/1", strb, op_ready); end
        total++; if (depth !== 2) begin bad++; $display("FAIL t2_depth got=%0d exp=2", depth); end
        step(1, 3'd2, 4'd0, 0);
        total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL t2_p1_ready got=%b exp=0", op_ready); end
        total++; if (strb !== 3'b001 || rf_din !== 2) begin bad++; $display("FAIL t2_p1 got=%b/%0h exp=001/2", strb, rf_din); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL t2_p1_rsp got=%b exp=0", rsp_valid); end
        step(1, 3'd2, 4'd0, 0);
        total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL t2_p2_ready got=%b exp=0", op_ready); end
        total++; if (strb !== 3'b001 || rf_din !== 1) begin bad++; $display("FAIL t2_p2 got=%b/%0h exp=001/1", strb, rf_din); end
        step(1, 3'd2, 4'd0, 0);
        total++; if (op_ready !== 1'b1 || rsp_valid !== 1'b1) begin bad++; $display("FAIL t2_done got=%b/%b exp=1/1", op_ready, rsp_valid); end
        total++; if (depth !== 2 || strb !== 3'b100) begin bad++; $display("FAIL t2_pop1_acc got=%0d/%b exp=2/100", depth, strb); end
        step(1, 3'd2, 4'd0, 0);
        total++; if (rsp_data !== 1 || depth !== 1) begin bad++; $display("FAIL t2_pop1 got=%0h/%0d exp=1/1", rsp_data, depth); end
        step(0, 3'd0, 4'd0, 0);
        total++; if (rsp_data !== 2 || depth !== 0) begin bad++; $display("FAIL t2_pop2 got=%0h/%0d exp=2/0", rsp_data, depth); end
        $display("test_swap done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_dup();
        step(1, 3'd1, 4'd0, 9);
        step(1, 3'd5, 4'd0, 0);
        total++; if (strb !== 3'b101 || rf_din !== 9) begin bad++; $display("FAIL t3_dup_acc got=%b/%0h exp=101/9", strb, rf_din); end
        step(1, 3'd2, 4'd0, 0);
        total++; if (op_ready !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL t3_dup_busy got=%b/%b exp=0/0", op_ready, rsp_valid); end
        total++; if (strb !== 3'b001 || rf_din !== 9) begin bad++; $display("FAIL t3_dup_push got=%b/%0h exp=001/9", strb, rf_din); end
        step(1, 3'd2, 4'd0, 0);
        total++; if (rsp_valid !== 1'b1 || depth !== 2) begin bad++; $display("FAIL t3_dup_done got=%b/%0d exp=1/2", rsp_valid, depth); end
        step(1, 3'd2, 4'd0, 0);
        total++; if (rsp_data !== 9 || depth !== 1) begin bad++; $display("FAIL t3_pop1 got=%0h/%0d exp=9/1", rsp_data, depth); end
        step(0, 3'd0, 4'd0, 0);
        total++; if (rsp_data !== 9 || depth !== 0) begin bad++; $display("FAIL t3_pop2 got=%0h/%0d exp=9/0", rsp_data, depth); end
        $display("test_dup done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_errors();
        step(1, 3'd2, 4'd0, 0);
        total++; if (strb !== 3'b000) begin bad++; $display("FAIL t4_under_strb got=%b exp=000", strb); end
        step(1, 3'd1, 4'd0, 3);
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 2'b01) begin bad++; $display("FAIL t4_pop_under got=%b/%b exp=1/01", rsp_valid, rsp_err); end
        total++; if (depth !== 0) begin bad++; $display("FAIL t4_under_depth got=%0d exp=0", depth); end
        step(1, 3'd3, 4'd1, 0);
        total++; if (strb !== 3'b000 || depth !== 1) begin bad++; $display("FAIL t4_binop_strb got=%b/%0d exp=000/1", strb, depth); end
        step(1, 3'd7, 4'd0, 0);
        total++; if (rsp_err !== 2'b01 || depth !== 1) begin bad++; $display("FAIL t4_binop_under got=%b/%0d exp=01/1", rsp_err, depth); end
        total++; if (strb !== 3'b000) begin bad++; $display("FAIL t4_ill_strb got=%b exp=000", strb); end
        step(1, 3'd4, 4'd3, 0);
        total++; if (rsp_err !== 2'b11) begin bad++; $display("FAIL t4_illegal got=%b exp=11", rsp_err); end
        total++; if (strb !== 3'b101 || rf_din !== 32'hFFFF_FFFC) begin bad++; $display("FAIL t4_unop got=%b/%0h exp=101/fffffffc", strb, rf_din); end
        step(1, 3'd2, 4'd0, 0);
        total++; if (rsp_err !== 2'b00 || depth !== 1) begin bad++; $display("FAIL t4_unop_rsp got=%b/%0d exp=00/1", rsp_err, depth); end
        step(0, 3'd0, 4'd0, 0);
        total++; if (rsp_data !== 32'hFFFF_FFFC || depth !== 0) begin bad++; $display("FAIL t4_pop got=%0h/%0d exp=fffffffc/0", rsp_data, depth); end
        $display("test_errors done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_overflow();
        step(1, 3'd1, 4'd0, 32'h10);
        step(1, 3'd1, 4'd0, 32'h20);
        step(1, 3'd1, 4'd0, 32'h30);
        step(1, 3'd1, 4'd0, 32'h40);
        step(1, 3'd1, 4'd0, 32'h50);
        total++; if (depth !== 4 || strb !== 3'b000) begin bad++; $display("FAIL t5_full_push got=%0d/%b exp=4/000", depth, strb); end
        step(1, 3'd5, 4'd0, 0);
        total++; if (rsp_err !== 2'b10 || depth !== 4) begin bad++; $display("FAIL t5_push_over got=%b/%0d exp=10/4", rsp_err, depth); end
        total++; if (strb !== 3'b000) begin bad++; $display("FAIL t5_dup_strb got=%b exp=000", strb); end
        step(1, 3'd2, 4'd0, 0);
        total++; if (rsp_err !== 2'b10 || depth !== 4 || op_ready !== 1'b1) begin bad++; $display("FAIL t5_dup_over got=%b/%0d/%b exp=10/4/1", rsp_err, depth, op_ready); end
        step(0, 3'd0, 4'd0, 0);
        total++; if (rsp_data !== 32'h40 || depth !== 3) begin bad++; $display("FAIL t5_top got=%0h/%0d exp=40/3", rsp_data, depth); end
        $display("test_overflow done total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_reset_mid_swap();
        rst_n = 1'b0;
        step(0, 3'd0, 4'd0, 0);
        rst_n = 1'b1;
        step(1, 3'd1, 4'd0, 1);
        step(1, 3'd1, 4'd0, 2);
        step(1, 3'd6, 4'd0, 0);
        step(0, 3'd0, 4'd0, 0);
        total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL t6_in_p1 got=%b exp=0", op_ready); end
        rst_n = 1'b0;
        step(0, 3'd0, 4'd0, 0);
        rst_n = 1'b1;
        total++; if (op_ready !== 1'b1 || depth !== 0) begin bad++; $display("FAIL t6_abort got=%b/%0d exp=1/0", op_ready, depth); end
        total++; if (rsp_valid !== 1'b0 || strb !== 3'b000) begin bad++; $display("FAIL t6_no_rsp got=%b/%b exp=0/000", rsp_valid, strb); end
        step(1, 3'd1, 4'd0, 32'hAA);
        step(1, 3'd2, 4'd0, 0);
        step(0, 3'd0, 4'd0, 0);
        total++; if (rsp_data !== 32'hAA || depth !== 0) begin bad++; $display("FAIL t6_after got=%0h/%0d exp=aa/0", rsp_data, depth); end
        $display("test_reset_mid_swap done total=%0d bad=%0d", total, bad);
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op_code = '0; op_fn = '0; op_data = '0;
        test_reset();
        test_push_binop_pop();
        test_swap();
        test_dup();
        test_errors();
        test_overflow();
        test_reset_mid_swap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
